// File: rtl/axis_header_inserter.sv
// Prepends a 0..BYTES byte header to an AXI4-Stream packet and re-packs the bytes
// so every output beat except the last is full; flags keep-protocol errors.
module axis_header_inserter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_hdr_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_hdr_tkeep,
  input  logic                    s_hdr_tvalid,
  output logic                    s_hdr_tready,
  input  logic [DATA_WIDTH-1:0]   s_data_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_data_tkeep,
  input  logic                    s_data_tvalid,
  output logic                    s_data_tready,
  input  logic                    s_data_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    err_keep
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = $clog2(BYTES + 1);

  typedef enum logic [1:0] {IDLE, BODY, TAIL} state_t;

  function automatic logic [BYTES-1:0] msb_mask(input int n);
    logic [BYTES-1:0] m;
    for (int i = 0; i < BYTES; i++) m[i] = (i >= BYTES - n);
    return m;
  endfunction

  function automatic logic [BYTES-1:0] lsb_mask(input int n);
    logic [BYTES-1:0] m;
    for (int i = 0; i < BYTES; i++) m[i] = (i < n);
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [BYTES-1:0] k);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < BYTES; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]         rcnt_q, rcnt_d;
  logic                  err_q, err_d;

  int                    hb, ln, n, r, sum;
  logic                  hdr_bad, mid_bad, last_bad, hdr_hs, data_hs;
  logic [DATA_WIDTH-1:0] hdr_aligned, in_shr, in_shl;

  // Residual bytes are kept MSB-aligned so output is a plain OR with the shifted input.
  always_comb begin
    hb = 0;
    for (int i = 0; i < BYTES; i++) if (s_hdr_tkeep[i] && hb == i) hb = i + 1;
    ln = 0;
    for (int i = 0; i < BYTES; i++) if (s_data_tkeep[BYTES-1-i] && ln == i) ln = i + 1;
    n           = (ln == 0) ? BYTES : ln;
    r           = int'(rcnt_q);
    sum         = r + n;
    hdr_bad     = (s_hdr_tkeep != lsb_mask(hb));
    mid_bad     = (s_data_tkeep != '1);
    last_bad    = (ln == 0) || (s_data_tkeep != msb_mask(ln));
    hdr_aligned = (s_hdr_tdata & byte_mask(lsb_mask(hb))) << (8 * (BYTES - hb));
    in_shr      = s_data_tdata >> (8 * r);
    in_shl      = s_data_tdata << (8 * (BYTES - r));
  end

  assign hdr_hs  = s_hdr_tvalid && s_hdr_tready;
  assign data_hs = s_data_tvalid && s_data_tready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hdr_hs) state_d = BODY;
      BODY:    if (data_hs && s_data_tlast) state_d = (sum <= BYTES) ? IDLE : TAIL;
      TAIL:    if (m_axis_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      rcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      res_q  <= res_d;
      rcnt_q <= rcnt_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    res_d  = res_q;
    rcnt_d = rcnt_q;
    err_d  = err_q;
    case (state_q)
      IDLE: if (hdr_hs) begin
        res_d  = hdr_aligned;
        rcnt_d = CW'(hb);
        if (hdr_bad) err_d = 1'b1;
      end
      BODY: if (data_hs) begin
        if (!s_data_tlast) begin
          res_d = in_shl;
          if (mid_bad) err_d = 1'b1;
        end else begin
          if (last_bad) err_d = 1'b1;
          if (sum <= BYTES) begin
            res_d  = '0;
            rcnt_d = '0;
          end else begin
            res_d  = in_shl & byte_mask(msb_mask(sum - BYTES));
            rcnt_d = CW'(sum - BYTES);
          end
        end
      end
      TAIL: if (m_axis_tready) begin
        res_d  = '0;
        rcnt_d = '0;
      end
      default: ;
    endcase
  end

  // In TAIL the residual count holds the leftover byte count.
  always_comb begin
    s_hdr_tready  = 1'b0;
    s_data_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    case (state_q)
      IDLE: s_hdr_tready = 1'b1;
      BODY: begin
        m_axis_tvalid = s_data_tvalid;
        s_data_tready = m_axis_tready;
        if (s_data_tvalid) begin
          m_axis_tdata = res_q | in_shr;
          if (s_data_tlast && sum <= BYTES) begin
            m_axis_tkeep = msb_mask(sum);
            m_axis_tlast = 1'b1;
          end else begin
            m_axis_tkeep = '1;
          end
        end
      end
      TAIL: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tdata  = res_q;
        m_axis_tkeep  = msb_mask(r);
      end
      default: ;
    endcase
    if (rst) begin
      s_hdr_tready  = 1'b0;
      s_data_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
    end
  end

  assign err_keep = err_q;

endmodule

// File: tb/tb_axis_header_inserter.sv
// Directed bench for axis_header_inserter at DATA_WIDTH=32: output beats are captured
// by a monitor and compared against hand-computed expected beats.
module tb_axis_header_inserter;
  localparam int DW = 32;
  localparam int BY = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_hdr_tdata;
  logic [BY-1:0] s_hdr_tkeep;
  logic          s_hdr_tvalid;
  logic          s_hdr_tready;
  logic [DW-1:0] s_data_tdata;
  logic [BY-1:0] s_data_tkeep;
  logic          s_data_tvalid;
  logic          s_data_tready;
  logic          s_data_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [BY-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          err_keep;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [BY-1:0] keep;
    logic          last;
  } beat_t;

  beat_t obs_q[$];
  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    random_ready = 1'b0;
  bit    stall_prev = 1'b0;
  beat_t stall_beat;

  axis_header_inserter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_hdr_tdata(s_hdr_tdata), .s_hdr_tkeep(s_hdr_tkeep),
    .s_hdr_tvalid(s_hdr_tvalid), .s_hdr_tready(s_hdr_tready),
    .s_data_tdata(s_data_tdata), .s_data_tkeep(s_data_tkeep),
    .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
    .s_data_tlast(s_data_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .err_keep(err_keep)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Capture handshaken beats and verify the output holds while stalled.
  always @(negedge clk) begin
    beat_t cur;
    cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    if (stall_prev && !rst) checkOutput("stall_hold", 64'(cur), 64'(stall_beat));
    if (m_axis_tvalid && m_axis_tready) obs_q.push_back(cur);
    stall_prev = m_axis_tvalid && !m_axis_tready && !rst;
    stall_beat = cur;
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyHeader(input logic [DW-1:0] d, input logic [BY-1:0] k);
    int cyc;
    s_hdr_tdata  = d;
    s_hdr_tkeep  = k;
    s_hdr_tvalid = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!s_hdr_tready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!s_hdr_tready) checkOutput("hdr_timeout", 64'(s_hdr_tready), 64'(1));
    tick();
    s_hdr_tvalid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic [BY-1:0] k, input logic l);
    int cyc;
    s_data_tdata  = d;
    s_data_tkeep  = k;
    s_data_tlast  = l;
    s_data_tvalid = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!s_data_tready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!s_data_tready) checkOutput("data_timeout", 64'(s_data_tready), 64'(1));
    tick();
    s_data_tvalid = 1'b0;
  endtask

  task automatic expectBeat(input logic [DW-1:0] d, input logic [BY-1:0] k, input logic l);
    exp_q.push_back({d, k, l});
  endtask

  task automatic checkPacket(input string tag);
    int cyc;
    cyc = 0;
    while (obs_q.size() < exp_q.size() && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    checkOutput({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) checkOutput($sformatf("%s_beat%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
    tick();
  endtask

  logic [DW-1:0] p4_data [5];

  initial begin
    rst = 1'b1;
    s_hdr_tdata = '0; s_hdr_tkeep = '0; s_hdr_tvalid = 1'b0;
    s_data_tdata = '0; s_data_tkeep = '0; s_data_tvalid = 1'b0; s_data_tlast = 1'b0;
    p4_data = '{32'h01020304, 32'h11121314, 32'h21222324, 32'h31323334, 32'h41424344};

    repeat (3) tick();
    @(negedge clk);
    checkOutput("rst_hdr_tready", 64'(s_hdr_tready), 64'(0));
    checkOutput("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_hdr_tready", 64'(s_hdr_tready), 64'(1));
    checkOutput("idle_data_tready", 64'(s_data_tready), 64'(0));
    checkOutput("idle_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    checkOutput("idle_m_tdata", 64'(m_axis_tdata), 64'(0));
    checkOutput("idle_err", 64'(err_keep), 64'(0));
    tick();

    // Packet 1: 3-byte header, data waiting in IDLE must be stalled, tail beat follows.
    s_data_tdata = 32'h11223344; s_data_tkeep = 4'hF; s_data_tlast = 1'b0; s_data_tvalid = 1'b1;
    tick(); tick();
    @(negedge clk);
    checkOutput("p1_idle_stall_ready", 64'(s_data_tready), 64'(0));
    checkOutput("p1_idle_stall_valid", 64'(m_axis_tvalid), 64'(0));
    tick();
    applyHeader(32'h00AABBCC, 4'b0111);
    applyStimulus(32'h11223344, 4'hF, 1'b0);
    applyStimulus(32'h55667788, 4'b1100, 1'b1);
    expectBeat(32'hAABBCC11, 4'hF, 1'b0);
    expectBeat(32'h22334455, 4'hF, 1'b0);
    expectBeat(32'h66000000, 4'b1000, 1'b1);
    checkPacket("p1");

    // Packet 2: 1-byte header merges into a single full last beat.
    applyHeader(32'h000000AA, 4'b0001);
    applyStimulus(32'h11223344, 4'b1110, 1'b1);
    expectBeat(32'hAA112233, 4'hF, 1'b1);
    checkPacket("p2");

    // Packet 3: empty header is a pass-through.
    applyHeader(32'h12345678, 4'b0000);
    applyStimulus(32'h01020304, 4'hF, 1'b0);
    applyStimulus(32'h05060708, 4'hF, 1'b0);
    applyStimulus(32'h090A0000, 4'b1100, 1'b1);
    expectBeat(32'h01020304, 4'hF, 1'b0);
    expectBeat(32'h05060708, 4'hF, 1'b0);
    expectBeat(32'h090A0000, 4'b1100, 1'b1);
    checkPacket("p3");

    // Packet 4: full header, once always-ready and once with random backpressure.
    for (int pass = 0; pass < 2; pass++) begin
      random_ready = (pass == 1);
      applyHeader(32'hDEADBEEF, 4'hF);
      for (int i = 0; i < 5; i++)
        applyStimulus(p4_data[i], (i == 4) ? 4'b1110 : 4'hF, i == 4);
      expectBeat(32'hDEADBEEF, 4'hF, 1'b0);
      for (int i = 0; i < 4; i++) expectBeat(p4_data[i], 4'hF, 1'b0);
      expectBeat(32'h41424300, 4'b1110, 1'b1);
      checkPacket(pass == 0 ? "p4_ready" : "p4_random");
    end
    random_ready = 1'b0;
    tick();

    // Packet 5: short keep on a non-last beat sets the sticky error.
    @(negedge clk);
    checkOutput("p5_err_before", 64'(err_keep), 64'(0));
    tick();
    applyHeader(32'h000000EE, 4'b0001);
    applyStimulus(32'hA1A2A3A4, 4'b0111, 1'b0);
    @(negedge clk);
    checkOutput("p5_err_rise", 64'(err_keep), 64'(1));
    tick();
    applyStimulus(32'hB1B2B3B4, 4'b1000, 1'b1);
    expectBeat(32'hEEA1A2A3, 4'hF, 1'b0);
    expectBeat(32'hA4B1B2B3, 4'b1100, 1'b1);
    checkPacket("p5");
    @(negedge clk);
    checkOutput("p5_err_sticky", 64'(err_keep), 64'(1));
    tick();

    // Packet 6: reset mid-body discards the packet and any residual bytes.
    applyHeader(32'h0000CAFE, 4'b0011);
    applyStimulus(32'h01020304, 4'hF, 1'b0);
    applyStimulus(32'h05060708, 4'hF, 1'b0);
    expectBeat(32'hCAFE0102, 4'hF, 1'b0);
    expectBeat(32'h03040506, 4'hF, 1'b0);
    s_data_tdata = 32'h0A0B0C0D; s_data_tkeep = 4'hF; s_data_tlast = 1'b0; s_data_tvalid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("p6_rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    checkOutput("p6_rst_data_tready", 64'(s_data_tready), 64'(0));
    checkOutput("p6_rst_hdr_tready", 64'(s_hdr_tready), 64'(0));
    checkOutput("p6_rst_m_tdata", 64'(m_axis_tdata), 64'(0));
    tick();
    rst = 1'b0;
    s_data_tvalid = 1'b0;
    checkPacket("p6a");
    @(negedge clk);
    checkOutput("p6_after_hdr_tready", 64'(s_hdr_tready), 64'(1));
    checkOutput("p6_after_err", 64'(err_keep), 64'(0));
    tick();
    applyHeader(32'h00000000, 4'b0000);
    applyStimulus(32'h99887766, 4'hF, 1'b1);
    expectBeat(32'h99887766, 4'hF, 1'b1);
    checkPacket("p6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
